// File: rtl/modadd_if.sv
// modadd_if: request/result handshake plus the mpadder start/done bus.
// The master side is the sequencer; the slave side is the requester together with the adder.
interface modadd_if #(parameter int N = 514);
    logic         req_valid;
    logic         req_ready;
    logic         req_op;
    logic [N-1:0] req_a;
    logic [N-1:0] req_b;
    logic [N-1:0] req_m;
    logic         res_valid;
    logic         res_ready;
    logic [N-1:0] res;
    logic         res_err;
    logic         add_start;
    logic         add_sub;
    logic [N-1:0] add_a;
    logic [N-1:0] add_b;
    logic [N:0]   add_c;
    logic         add_done;
    modport master (
        input  req_valid, req_op, req_a, req_b, req_m, res_ready, add_c, add_done,
        output req_ready, res_valid, res, res_err, add_start, add_sub, add_a, add_b
    );
    modport slave (
        output req_valid, req_op, req_a, req_b, req_m, res_ready, add_c, add_done,
        input  req_ready, res_valid, res, res_err, add_start, add_sub, add_a, add_b
    );
endinterface

// File: rtl/modadd_ctrl.sv
// modadd_ctrl: sequences a shared mpadder through a raw add/sub pass and an optional
// correction-by-M pass to produce (A +/- B) mod M, with a timeout on lost add_done.
module modadd_ctrl #(
    parameter int N       = 514,
    parameter int TIMEOUT = 16
) (
    input logic     clk,
    input logic     rst,
    modadd_if.master bus
);
    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, ISSUE1, WAIT1, ISSUE2, WAIT2, OUT, ERR} state_t;

    state_t       state, next;
    logic [CW-1:0] cnt;
    logic         op;
    logic [N-1:0] m;
    logic [N-1:0] res_q;
    logic         waiting, done, lost;

    assign waiting = state == WAIT1 || state == WAIT2;
    assign done    = waiting && bus.add_done;
    assign lost    = waiting && !bus.add_done && cnt == CW'(TIMEOUT);

    always_ff @(posedge clk)
        state <= rst ? IDLE : next;

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = bus.req_valid ? ISSUE1 : IDLE;
            ISSUE1:  next = WAIT1;
            WAIT1:   next = done ? ((op && !bus.add_c[N]) ? OUT : ISSUE2) : lost ? ERR : WAIT1;
            ISSUE2:  next = WAIT2;
            WAIT2:   next = done ? OUT : lost ? ERR : WAIT2;
            OUT:     next = bus.res_ready ? IDLE : OUT;
            ERR:     next = bus.res_ready ? IDLE : ERR;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready = state == IDLE;
        bus.add_start = state == ISSUE1 || state == ISSUE2;
        bus.res_valid = state == OUT || state == ERR;
        bus.res_err   = state == ERR;
        bus.res       = state == OUT ? res_q : '0;
    end

    // add_a doubles as storage for the pass-1 sum S, needed when pass 2 borrows
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.add_a   <= '0;
            bus.add_b   <= '0;
            bus.add_sub <= 1'b0;
            op          <= 1'b0;
            m           <= '0;
            res_q       <= '0;
            cnt         <= '0;
        end else begin
            cnt <= waiting ? cnt + CW'(1) : '0;
            if (state == IDLE && bus.req_valid) begin
                bus.add_a   <= bus.req_a;
                bus.add_b   <= bus.req_b;
                bus.add_sub <= bus.req_op;
                op          <= bus.req_op;
                m           <= bus.req_m;
            end
            if (state == WAIT1 && bus.add_done) begin
                bus.add_a   <= bus.add_c[N-1:0];
                bus.add_b   <= m;
                bus.add_sub <= !op;
                res_q       <= bus.add_c[N-1:0];
            end
            if (state == WAIT2 && bus.add_done)
                res_q <= (!op && bus.add_c[N]) ? bus.add_a : bus.add_c[N-1:0];
        end
    end
endmodule

// File: tb/tb_modadd_ctrl.sv
// tb_modadd_ctrl: randomized and directed checks of modadd_ctrl against a modular-arithmetic
// model, with a fixed-latency stub adder that can be told to never answer.
module tb_modadd_ctrl;
    localparam int N  = 514;
    localparam int TO = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    modadd_if #(.N(N)) bus ();
    modadd_ctrl #(.N(N), .TIMEOUT(TO)) dut (.clk(clk), .rst(rst), .bus(bus));

    int total = 0;
    int bad   = 0;
    bit dead  = 1'b0;

    task automatic chk(input string name, input logic [N:0] got, input logic [N:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [N-1:0] golden(input logic op, input logic [N-1:0] a, b, m);
        logic [N+1:0] w;
        if (!op) begin
            w = {2'b0, a} + {2'b0, b};
            if (w >= {2'b0, m}) w = w - {2'b0, m};
        end else
            w = (a >= b) ? {2'b0, a} - {2'b0, b} : {2'b0, a} + {2'b0, m} - {2'b0, b};
        return w[N-1:0];
    endfunction

    function automatic logic [N-1:0] rnd();
        logic [N-1:0] v = '0;
        for (int i = 0; i < (N + 31) / 32; i++) v = (v << 32) | N'($urandom);
        return v;
    endfunction

    // stub mpadder: operands sampled in the start cycle, done six cycles later
    initial begin
        int dly = 0;
        logic [N:0] c = '0;
        logic s, sb, r;
        logic [N-1:0] a, b;
        bus.add_done = 1'b0;
        bus.add_c    = '0;
        forever begin
            @(negedge clk);
            s = bus.add_start; a = bus.add_a; b = bus.add_b; sb = bus.add_sub; r = rst;
            @(posedge clk);
            #1;
            bus.add_done = 1'b0;
            if (r) dly = 0;
            else if (s === 1'b1) begin
                dly = 5;
                c = sb ? {1'b0, a} - {1'b0, b} : {1'b0, a} + {1'b0, b};
            end else if (dly > 0) begin
                dly--;
                if (dly == 0 && !dead) begin
                    bus.add_done = 1'b1;
                    bus.add_c    = c;
                end
            end
        end
    end

    // compare process: expectations fixed at acceptance, checked every cycle
    initial begin
        bit busy = 1'b0, two = 1'b0, eop = 1'b0, eerr = 1'b0;
        int cyc = 0, lat = 0;
        logic [N-1:0] ea, eb, em, eres, es;
        forever begin
            @(negedge clk);
            if (rst) busy = 1'b0;
            else if (busy) begin
                cyc++;
                chk("req_ready_busy", bus.req_ready, 0);
                chk("add_start", bus.add_start, (cyc == 1 || (two && cyc == 8)));
                if (cyc == 1) begin
                    chk("p1_a", bus.add_a, ea);
                    chk("p1_b", bus.add_b, eb);
                    chk("p1_sub", bus.add_sub, eop);
                end
                if (two && cyc == 8) begin
                    chk("p2_a", bus.add_a, es);
                    chk("p2_b", bus.add_b, em);
                    chk("p2_sub", bus.add_sub, !eop);
                end
                chk("res_valid", bus.res_valid, cyc >= lat);
                if (bus.res_valid) begin
                    chk("res", bus.res, eres);
                    chk("res_err", bus.res_err, eerr);
                    if (bus.res_ready) busy = 1'b0;
                end
            end else begin
                chk("idle_req_ready", bus.req_ready, 1);
                chk("idle_res_valid", bus.res_valid, 0);
                chk("idle_add_start", bus.add_start, 0);
                if (bus.req_valid && bus.req_ready) begin
                    ea = bus.req_a; eb = bus.req_b; em = bus.req_m; eop = bus.req_op;
                    es = eop ? ea - eb : ea + eb;
                    if (dead) begin
                        eerr = 1'b1; eres = '0; two = 1'b0; lat = TO + 3;
                    end else begin
                        eerr = 1'b0; eres = golden(eop, ea, eb, em);
                        two = !(eop && ea >= eb);
                        lat = two ? 15 : 8;
                    end
                    busy = 1'b1;
                    cyc  = 0;
                end
            end
        end
    end

    task automatic wait_accept();
        bit ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            ok = bus.req_valid && bus.req_ready;
        end
        chk("accept_seen", ok, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid();
        bit ok = 1'b0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            ok = bus.res_valid;
        end
        chk("res_valid_seen", ok, 1);
    endtask

    task automatic consume(input int hold);
        repeat (hold + 1) @(posedge clk);
        #1 bus.res_ready = 1'b1;
        @(posedge clk);
        #1 bus.res_ready = 1'b0;
    endtask

    task automatic run(input logic op, input logic [N-1:0] a, b, m, input int hold);
        bus.req_op = op; bus.req_a = a; bus.req_b = b; bus.req_m = m;
        bus.req_valid = 1'b1;
        wait_accept();
        bus.req_valid = 1'b0;
        wait_valid();
        consume(hold);
    endtask

    initial begin
        logic [N-1:0] a, b, m;
        bus.req_valid = 1'b0; bus.req_op = 1'b0; bus.res_ready = 1'b0;
        bus.req_a = '0; bus.req_b = '0; bus.req_m = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("pin_add_wrap", golden(0, 7, 9, 13), 3);
        chk("pin_add_keep", golden(0, 2, 3, 13), 5);
        chk("pin_add_eqm", golden(0, 6, 7, 13), 0);
        chk("pin_sub_borrow", golden(1, 3, 5, 13), 11);
        chk("pin_sub_plain", golden(1, 5, 3, 13), 2);
        chk("pin_sub_eq", golden(1, 4, 4, 13), 0);
        chk("pin_sub_edge", golden(1, 0, 12, 13), 1);
        run(0, 7, 9, 13, 0);
        run(0, 2, 3, 13, 0);
        run(0, 6, 7, 13, 1);
        run(1, 3, 5, 13, 0);
        run(1, 5, 3, 13, 0);
        run(1, 4, 4, 13, 0);
        run(1, 0, 12, 13, 2);
        // stalled consumer with a second request waiting
        bus.req_op = 0; bus.req_a = 7; bus.req_b = 9; bus.req_m = 13;
        bus.req_valid = 1'b1;
        wait_accept();
        bus.req_op = 1; bus.req_a = 5; bus.req_b = 3;
        wait_valid();
        consume(10);
        wait_accept();
        bus.req_valid = 1'b0;
        wait_valid();
        consume(0);
        // adder never answers, then recovers
        dead = 1'b1;
        run(0, 7, 9, 13, 0);
        dead = 1'b0;
        run(0, 7, 9, 13, 0);
        // reset during WAIT1
        bus.req_op = 0; bus.req_a = 1; bus.req_b = 2; bus.req_m = 13;
        bus.req_valid = 1'b1;
        wait_accept();
        bus.req_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 1000; i++) begin
            m = rnd();
            m[N-1:512] = '0;
            m[511] = 1'b1;
            a = rnd() % m;
            b = rnd() % m;
            run(1'($urandom_range(0, 1)), a, b, m, int'($urandom_range(0, 2)));
        end
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
